// File: rtl/booth_mul_pkg.sv
// booth_mul_pkg: controller state encoding and radix-2 Booth decode constants
// shared by booth_mul_seq and the booth_addsub datapath.
package booth_mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Decode of {Q[0], Qm}: 01 adds M, 10 subtracts M, 00/11 leave A alone.
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/booth_addsub.sv
// booth_addsub: W-bit combinational add/subtract/pass selected by a Booth
// {Q0,Qm} decode; carry-out is discarded (modulo 2^W).
module booth_addsub
    import booth_mul_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] m_i,
    input  logic [1:0]   dec_i,
    output logic [W-1:0] sum_o
);

    always_comb begin
        sum_o = a_i;
        case (dec_i)
            BOOTH_ADD: sum_o = a_i + m_i;
            BOOTH_SUB: sum_o = a_i - m_i;
            default:   sum_o = a_i;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier with start/busy/done handshake.
// Optional macro BOOTH_MUL_OVF_EN adds the c_ovf overflow output.
module booth_mul_seq
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic               c_clk,
    input  logic               c_reset,
    input  logic               c_start,
    input  logic               c_signed,
    input  logic [WIDTH-1:0]   c_multiplicand,
    input  logic [WIDTH-1:0]   c_multiplier,
    output logic               c_busy,
    output logic               c_done,
    output logic [2*WIDTH-1:0] c_product
`ifdef BOOTH_MUL_OVF_EN
    ,
    output logic               c_ovf
`endif
);

    localparam int W1 = WIDTH + 1;

    state_e               state_q, state_d;
    logic [W1-1:0]        a_q, a_d;
    logic [W1-1:0]        q_q, q_d;
    logic [W1-1:0]        m_q, m_d;
    logic                 qm_q, qm_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [W1-1:0]        sum;
    logic [2*WIDTH-1:0]   finalProd;

`ifdef BOOTH_MUL_OVF_EN
    logic                 signed_q, signed_d;
    logic                 ovf_q, ovf_d;
    logic                 finalOvf;
`endif

    booth_addsub #(
        .W(W1)
    ) u_addsub (
        .a_i  (a_q),
        .m_i  (m_q),
        .dec_i({q_q[0], qm_q}),
        .sum_o(sum)
    );

    // Low 2*WIDTH bits of {A,Q} after the final arithmetic shift, taken straight from pre-shift A/Q.
    assign finalProd = {a_q[WIDTH-1:0], q_q[WIDTH:1]};

`ifdef BOOTH_MUL_OVF_EN
    always_comb begin
        if (signed_q) begin
            finalOvf = !((&finalProd[2*WIDTH-1:WIDTH-1]) || !(|finalProd[2*WIDTH-1:WIDTH-1]));
        end else begin
            finalOvf = |finalProd[2*WIDTH-1:WIDTH];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        qm_d    = qm_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
`ifdef BOOTH_MUL_OVF_EN
        signed_d = signed_q;
        ovf_d    = ovf_q;
`endif
        c_busy  = 1'b0;
        c_done  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (c_start) begin
                    m_d     = {c_signed & c_multiplicand[WIDTH-1], c_multiplicand};
                    q_d     = {c_signed & c_multiplier[WIDTH-1], c_multiplier};
                    a_d     = '0;
                    qm_d    = 1'b0;
                    cnt_d   = CNT_W'(W1);
`ifdef BOOTH_MUL_OVF_EN
                    signed_d = c_signed;
`endif
                    state_d = EVAL;
                end
            end
            EVAL: begin
                c_busy  = 1'b1;
                a_d     = sum;
                state_d = SHIFT;
            end
            SHIFT: begin
                c_busy = 1'b1;
                a_d    = {a_q[W1-1], a_q[W1-1:1]};
                q_d    = {a_q[0], q_q[W1-1:1]};
                qm_d   = q_q[0];
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    prod_d  = finalProd;
`ifdef BOOTH_MUL_OVF_EN
                    ovf_d   = finalOvf;
`endif
                    state_d = DONE;
                end else begin
                    state_d = EVAL;
                end
            end
            DONE: begin
                c_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (c_reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qm_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
`ifdef BOOTH_MUL_OVF_EN
            signed_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            qm_q    <= qm_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
`ifdef BOOTH_MUL_OVF_EN
            signed_q <= signed_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign c_product = prod_q;
`ifdef BOOTH_MUL_OVF_EN
    assign c_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: self-checking bench for booth_mul_seq (WIDTH=8): vector table,
// hand-written handshake/reset sequences, and random operands against an arithmetic model.
module tb_booth_mul_seq;

    localparam int W          = 8;
    localparam int NUM_RANDOM = 200;
    localparam int LATENCY    = 2 * W + 2;
    localparam int MAX_WAIT   = 100;

    typedef struct {
        logic [W-1:0]   mcand;
        logic [W-1:0]   mplier;
        logic           sgn;
        logic [2*W-1:0] expProd;
        logic           expOvf;
    } vector_t;

    logic           clk;
    logic           reset;
    logic           start;
    logic           signedMode;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
`ifdef BOOTH_MUL_OVF_EN
    logic           ovf;
`endif

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    booth_mul_seq #(
        .WIDTH(W)
    ) dut (
        .c_clk         (clk),
        .c_reset       (reset),
        .c_start       (start),
        .c_signed      (signedMode),
        .c_multiplicand(multiplicand),
        .c_multiplier  (multiplier),
        .c_busy        (busy),
        .c_done        (done),
        .c_product     (product)
`ifdef BOOTH_MUL_OVF_EN
        ,
        .c_ovf         (ovf)
`endif
    );

    // Operand value as a mathematical integer under the selected interpretation.
    function automatic longint opValue(input logic [W-1:0] x, input logic sgn);
        longint v;
        v = longint'(x);
        if (sgn && x[W-1]) v = v - (longint'(1) << W);
        return v;
    endfunction

    function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b,
                                                   input logic sgn);
        longint p;
        p = opValue(a, sgn) * opValue(b, sgn);
        return p[2*W-1:0];
    endfunction

    function automatic logic refOvf(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        longint p;
        p = opValue(a, sgn) * opValue(b, sgn);
        if (sgn) return (p < -(longint'(1) << (W - 1))) || (p > (longint'(1) << (W - 1)) - 1);
        return p > (longint'(1) << W) - 1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one multiply from IDLE, scrambles the inputs after the sampling edge,
    // then checks latency, result, overflow and the one-cycle done pulse.
    task automatic applyStimulus(input string tag, input logic [W-1:0] mcand, input logic [W-1:0] mplier,
                                 input logic sgn, input logic [W-1:0] postMcand,
                                 input logic [W-1:0] postMplier, input logic [2*W-1:0] expProd,
                                 input logic expOvf);
        int   edges;
        logic seen;
        @(negedge clk);
        multiplicand = mcand;
        multiplier   = mplier;
        signedMode   = sgn;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = postMcand;
        multiplier   = postMplier;
        signedMode   = ~sgn;
        checkOutput({tag, ".busyAfterStart"}, 64'(busy), 64'd1);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < MAX_WAIT) begin
            @(posedge clk);
            #1;
            edges++;
            seen = done;
        end
        checkOutput({tag, ".doneSeen"}, 64'(seen), 64'd1);
        checkOutput({tag, ".latency"}, 64'(edges), 64'(LATENCY));
        checkOutput({tag, ".product"}, 64'(product), 64'(expProd));
`ifdef BOOTH_MUL_OVF_EN
        checkOutput({tag, ".ovf"}, 64'(ovf), 64'(expOvf));
`endif
        @(posedge clk);
        #1;
        checkOutput({tag, ".donePulse"}, 64'(done), 64'd0);
        checkOutput({tag, ".heldProduct"}, 64'(product), 64'(expProd));
    endtask

    vector_t vectors[$];

    initial begin
        int   edges;
        logic seen;
        logic [W-1:0] ra, rb;
        logic rs;

        vectors = '{
            '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1},
            '{8'h80, 8'h80, 1'b1, 16'h4000, 1'b1},
            '{8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1},
            '{8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0},
            '{8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b1},
            '{8'h05, 8'h06, 1'b0, 16'h001E, 1'b0},
            '{8'h7F, 8'h7F, 1'b1, 16'h3F01, 1'b1},
            '{8'h01, 8'hFF, 1'b1, 16'hFFFF, 1'b0},
            '{8'h80, 8'h01, 1'b0, 16'h0080, 1'b0},
            '{8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0},
            '{8'h00, 8'hA5, 1'b1, 16'h0000, 1'b0}
        };

        reset        = 1'b1;
        start        = 1'b0;
        signedMode   = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.product", 64'(product), 64'd0);
`ifdef BOOTH_MUL_OVF_EN
        checkOutput("reset.ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        foreach (vectors[i]) begin
            applyStimulus($sformatf("vec%0d", i), vectors[i].mcand, vectors[i].mplier, vectors[i].sgn,
                          W'($urandom), W'($urandom), vectors[i].expProd, vectors[i].expOvf);
        end

        // Reset while the 7x3 op is in SHIFT discards it and zeroes the held product.
        @(negedge clk);
        multiplicand = 8'd7;
        multiplier   = 8'd3;
        signedMode   = 1'b0;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midReset.busyBefore", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midReset.busy", 64'(busy), 64'd0);
        checkOutput("midReset.done", 64'(done), 64'd0);
        checkOutput("midReset.product", 64'(product), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("afterReset", 8'd5, 8'd6, 1'b0, 8'd0, 8'd0, 16'd30, 1'b0);

        // Start held high: ignored while busy and in DONE, re-accepted in the following IDLE cycle.
        @(negedge clk);
        multiplicand = 8'd6;
        multiplier   = 8'd7;
        signedMode   = 1'b0;
        start        = 1'b1;
        @(posedge clk);
        #1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < MAX_WAIT) begin
            @(posedge clk);
            #1;
            edges++;
            seen = done;
        end
        checkOutput("heldStart.doneSeen", 64'(seen), 64'd1);
        checkOutput("heldStart.latency", 64'(edges), 64'(LATENCY));
        checkOutput("heldStart.product", 64'(product), 64'd42);
        @(posedge clk);
        #1;
        checkOutput("heldStart.idleBusy", 64'(busy), 64'd0);
        checkOutput("heldStart.idleDone", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("heldStart.reaccept", 64'(busy), 64'd1);
        start = 1'b0;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < MAX_WAIT) begin
            @(posedge clk);
            #1;
            edges++;
            seen = done;
        end
        checkOutput("heldStart.secondDone", 64'(seen), 64'd1);
        checkOutput("heldStart.secondLatency", 64'(edges), 64'(LATENCY));
        checkOutput("heldStart.secondProduct", 64'(product), 64'd42);
        @(posedge clk);
        #1;

        // Operands change right after sampling; result must still be 2x3 and hold in IDLE.
        applyStimulus("opChange", 8'd2, 8'd3, 1'b0, 8'd9, 8'd9, 16'd6, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold%0d.product", i), 64'(product), 64'd6);
            checkOutput($sformatf("hold%0d.done", i), 64'(done), 64'd0);
        end

        for (int i = 0; i < NUM_RANDOM; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            applyStimulus($sformatf("rand%0d", i), ra, rb, rs, W'($urandom), W'($urandom),
                          refProduct(ra, rb, rs), refOvf(ra, rb, rs));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
